tpu_seq: RTL and testbench
==========================

TPU_SEQ -- requirements
Module: tpu_seq

Interface
REQ-001 Parameter DATAW, default 64, SHALL set the host data and TPU data width.
REQ-002 Parameter ADDRW, default 16, SHALL set the TPU address width.
REQ-003 Parameter MM_CYCLES, default 23, SHALL set the number of wait cycles after a matmul launch.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port cmd_valid, input, 1 bit: the host command is valid.
REQ-007 Port cmd_ready, output, 1 bit: the sequencer can accept a command.
REQ-008 Port cmd_op, input, 3 bits: opcode; 0 NOP, 1 WR_A, 2 WR_B, 3 WR_C, 4 MATMUL, 5 RD_C, 6/7 illegal.
REQ-009 Port cmd_row, input, 3 bits: matrix row index.
REQ-010 Port cmd_half, input, 1 bit: C half-row select (0 = cols 0-3, 1 = cols 4-7).
REQ-011 Port cmd_data, input, DATAW bits: write payload.
REQ-012 Port rsp_valid, output, 1 bit: read data is valid.
REQ-013 Port rsp_ready, input, 1 bit: the host accepts the response.
REQ-014 Port rsp_data, output, DATAW bits: captured C half-row.
REQ-015 Port tpu_addr, output, ADDRW bits: TPU address bus.
REQ-016 Port tpu_r_w, output, 1 bit: TPU direction; 1 = write, 0 = read.
REQ-017 Port tpu_wdata, output, DATAW bits: drives the TPU dataIn port.
REQ-018 Port tpu_rdata, input, DATAW bits: driven from the TPU dataOut port.
REQ-019 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-020 Port mm_done, output, 1 bit: one-cycle pulse when the matmul wait completes.
REQ-021 Port err, output, 1 bit: one-cycle pulse when an illegal opcode is accepted.

Function
REQ-022 The FSM SHALL have the states IDLE, ISSUE, HOLD, MM_WAIT, RSP; cmd_ready SHALL be 1 only in IDLE.
REQ-023 A command SHALL be accepted on cmd_valid & cmd_ready; op, row, half and data SHALL be registered, and the next state SHALL be ISSUE.
REQ-024 When the bus is idle (IDLE, MM_WAIT, RSP), tpu_addr SHALL be 0x0000, tpu_r_w 0 and tpu_wdata 0.
REQ-025 Address map: WR_A = 0x0100+row*8; WR_B = 0x0200+row*8; WR_C/RD_C = 0x0300+row*16+half*8; MATMUL = 0x0400.
REQ-026 WR_A/WR_B: ISSUE SHALL drive the address, r_w=1 and the data for exactly 1 cycle, then go to IDLE.
REQ-027 WR_C: ISSUE and then HOLD SHALL drive an identical address, r_w=1 and data for exactly 2 consecutive cycles, then go to IDLE.
REQ-028 MATMUL: ISSUE SHALL drive 0x0400 with r_w=1 for 1 cycle, then MM_WAIT SHALL count MM_CYCLES cycles.
REQ-029 MATMUL completion: mm_done SHALL pulse on the last MM_WAIT cycle, then the FSM SHALL go to IDLE.
REQ-030 RD_C: ISSUE and HOLD SHALL drive the address with r_w=0 for 2 cycles; tpu_rdata SHALL be captured into rsp_data at the end of HOLD, then the FSM SHALL go to RSP.
REQ-031 RSP: rsp_valid SHALL be held at 1 and rsp_data held stable until rsp_ready=1; the FSM SHALL go to IDLE on the cycle after the handshake.
REQ-032 NOP SHALL cause no bus activity; the FSM SHALL go ISSUE then IDLE with the bus idle.
REQ-033 Illegal opcodes SHALL cause no bus activity; err SHALL pulse 1 cycle during ISSUE, then the FSM SHALL go to IDLE.
REQ-034 Back-to-back commands: the earliest next acceptance SHALL be the cycle after return to IDLE; commands SHALL never overlap on the bus.
REQ-035 rsp_ready asserted outside RSP SHALL be ignored.
REQ-036 cmd_row and cmd_half SHALL be used unmodified (3 bits and 1 bit), so no address can wrap beyond the region of the decoded op.
REQ-037 The matmul counter SHALL be $clog2(MM_CYCLES+1) bits wide, SHALL clear on entry to MM_WAIT, and SHALL not wrap.

Reset
REQ-038 While rst=1, state SHALL be IDLE, the counter 0, rsp_valid 0, rsp_data 0, mm_done 0, err 0, busy 0, and the bus idle.
REQ-039 Reset mid-operation (HOLD, MM_WAIT, RSP) SHALL abandon the command immediately, with no completion pulse and no response.
REQ-040 cmd_ready SHALL be 0 while rst=1 and SHALL become 1 in the first cycle after release.

Verification
REQ-041 WR_A row 3, data 0x0807060504030201 -> tpu_addr 0x0118, r_w 1, data matching for exactly 1 cycle; cmd_ready 0 that cycle.
REQ-042 WR_C row 2 half 1 -> tpu_addr 0x0328, r_w 1 for 2 consecutive cycles; then the bus idles at 0x0000.
REQ-043 MATMUL -> 0x0400 for 1 cycle; mm_done pulses exactly 23 cycles later; cmd_valid held high is not accepted until after mm_done.
REQ-044 RD_C row 7 half 0 with tpu_rdata=0xAAAA5555 1234FFFF, and rsp_ready held 0 for 5 cycles -> addr 0x0370, r_w 0 for 2 cycles; rsp_valid held with stable data; IDLE the cycle after rsp_ready.
REQ-045 Opcode 6 -> err pulses for 1 cycle, the bus never leaves idle, and busy is high for exactly 1 cycle.
REQ-046 rst asserted mid MM_WAIT (count 10) -> all outputs take their reset values asynchronously; no mm_done; the next MATMUL waits a full 23 cycles.

Source files
------------

// File: rtl/tpu_seq.sv
// Host-command sequencer for the TPU bus: decodes one command at a time into
// TPU write/read cycles, a timed matmul wait, and a held read response.
module tpu_seq #(
  parameter int DATAW     = 64,
  parameter int ADDRW     = 16,
  parameter int MM_CYCLES = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_row,
  input  logic             cmd_half,
  input  logic [DATAW-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATAW-1:0] rsp_data,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata,
  output logic             busy,
  output logic             mm_done,
  output logic             err
);

  localparam int CW = $clog2(MM_CYCLES + 1);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_WR_A   = 3'd1;
  localparam logic [2:0] OP_WR_B   = 3'd2;
  localparam logic [2:0] OP_WR_C   = 3'd3;
  localparam logic [2:0] OP_MATMUL = 3'd4;
  localparam logic [2:0] OP_RD_C   = 3'd5;

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, MM_WAIT, RSP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [2:0]       row_q;
  logic             half_q;
  logic [DATAW-1:0] data_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DATAW-1:0] rsp_data_q, rsp_data_d;
  logic [ADDRW-1:0] op_addr;
  logic             accept;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;

  // Row and half go straight into the low address bits, so no carry can leave the op's region.
  always_comb begin
    op_addr = '0;
    case (op_q)
      OP_WR_A:          op_addr = ADDRW'(32'h0100) | ADDRW'({row_q, 3'b000});
      OP_WR_B:          op_addr = ADDRW'(32'h0200) | ADDRW'({row_q, 3'b000});
      OP_WR_C, OP_RD_C: op_addr = ADDRW'(32'h0300) | ADDRW'({row_q, half_q, 3'b000});
      OP_MATMUL:        op_addr = ADDRW'(32'h0400);
      default:          op_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      row_q      <= '0;
      half_q     <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      if (accept) begin
        op_q   <= cmd_op;
        row_q  <= cmd_row;
        half_q <= cmd_half;
        data_q <= cmd_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    tpu_addr   = '0;
    tpu_r_w    = 1'b0;
    tpu_wdata  = '0;
    rsp_valid  = 1'b0;
    mm_done    = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = IDLE;
        case (op_q)
          OP_NOP: ;
          OP_WR_A, OP_WR_B: begin
            tpu_addr  = op_addr;
            tpu_r_w   = 1'b1;
            tpu_wdata = data_q;
          end
          OP_WR_C: begin
            tpu_addr  = op_addr;
            tpu_r_w   = 1'b1;
            tpu_wdata = data_q;
            state_d   = HOLD;
          end
          OP_MATMUL: begin
            tpu_addr = op_addr;
            tpu_r_w  = 1'b1;
            cnt_d    = '0;
            state_d  = MM_WAIT;
          end
          OP_RD_C: begin
            tpu_addr = op_addr;
            state_d  = HOLD;
          end
          default: err = 1'b1;
        endcase
      end
      HOLD: begin
        tpu_addr = op_addr;
        if (op_q == OP_RD_C) begin
          rsp_data_d = tpu_rdata;
          state_d    = RSP;
        end else begin
          tpu_r_w   = 1'b1;
          tpu_wdata = data_q;
          state_d   = IDLE;
        end
      end
      MM_WAIT: begin
        if (cnt_q == CW'(MM_CYCLES - 1)) begin
          mm_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tpu_seq.sv
// Self-checking bench for tpu_seq: directed scenarios plus random commands,
// checked cycle by cycle against a per-command timeline model.
module tb_tpu_seq;
  localparam int DATAW = 64;
  localparam int ADDRW = 16;
  localparam int MM    = 23;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_row;
  logic             cmd_half;
  logic [DATAW-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DATAW-1:0] rsp_data;
  logic [ADDRW-1:0] tpu_addr;
  logic             tpu_r_w;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;
  logic             busy;
  logic             mm_done;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  tpu_seq #(.DATAW(DATAW), .ADDRW(ADDRW), .MM_CYCLES(MM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_half(cmd_half), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_wdata(tpu_wdata),
    .tpu_rdata(tpu_rdata), .busy(busy), .mm_done(mm_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_addr(input int op, input int row, input int half);
    case (op)
      1:       return 16'(32'h0100 + row * 8);
      2:       return 16'(32'h0200 + row * 8);
      3, 5:    return 16'(32'h0300 + row * 16 + half * 8);
      4:       return 16'h0400;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_idle_bus(input string tag);
    check({tag, "_addr"},  64'(tpu_addr),  64'h0);
    check({tag, "_rw"},    64'(tpu_r_w),   64'h0);
    check({tag, "_wdata"}, tpu_wdata,      64'h0);
  endtask

  // One command from acceptance to the first idle cycle after it.
  task automatic run_cmd(input int op, input int row, input int half,
                         input logic [63:0] data, input logic [63:0] rdata,
                         input int stall, input bit hold_valid);
    int  nbus, nbusy;
    bit  is_wr, is_rd, has_data;
    nbus     = (op == 1 || op == 2 || op == 4) ? 1 : (op == 3 || op == 5) ? 2 : 0;
    is_wr    = (op >= 1 && op <= 4);
    has_data = (op >= 1 && op <= 3);
    is_rd    = (op == 5);
    nbusy    = (op == 4) ? 1 + MM : (op == 5) ? 3 + stall : (op == 3) ? 2 : 1;
    @(negedge clk);
    check("pre_ready", 64'(cmd_ready), 64'h1);
    check("pre_busy",  64'(busy),      64'h0);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_row   = 3'(row);
    cmd_half  = 1'(half);
    cmd_data  = data;
    rsp_ready = 1'($urandom);
    tpu_rdata = {$urandom, $urandom};
    for (int i = 0; i < nbusy; i++) begin
      @(negedge clk);
      check("busy",      64'(busy),      64'h1);
      check("ready",     64'(cmd_ready), 64'h0);
      check("addr",      64'(tpu_addr),  64'((i < nbus) ? ref_addr(op, row, half) : 16'h0));
      check("r_w",       64'(tpu_r_w),   64'(is_wr && i < nbus));
      check("wdata",     tpu_wdata,      (has_data && i < nbus) ? data : 64'h0);
      check("err",       64'(err),       64'(op >= 6 && i == 0));
      check("mm_done",   64'(mm_done),   64'(op == 4 && i == MM));
      check("rsp_valid", 64'(rsp_valid), 64'(is_rd && i >= 2));
      if (is_rd && i >= 2) check("rsp_data", rsp_data, rdata);
      cmd_valid = hold_valid;
      rsp_ready = (is_rd && i >= 2) ? (i == 2 + stall) : 1'($urandom);
      tpu_rdata = (is_rd && i == 1) ? rdata : {$urandom, $urandom};
    end
    @(negedge clk);
    check("post_busy",  64'(busy),      64'h0);
    check("post_ready", 64'(cmd_ready), 64'h1);
    check_idle_bus("post");
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_row   = '0;
    cmd_half  = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    tpu_rdata = '0;
    #2;
    check("rst_ready",   64'(cmd_ready), 64'h0);
    check("rst_busy",    64'(busy),      64'h0);
    check("rst_rspv",    64'(rsp_valid), 64'h0);
    check("rst_rspd",    rsp_data,       64'h0);
    check("rst_mmdone",  64'(mm_done),   64'h0);
    check("rst_err",     64'(err),       64'h0);
    check_idle_bus("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(cmd_ready), 64'h1);

    run_cmd(1, 3, 0, 64'h0807060504030201, 64'h0, 0, 1'b0);
    run_cmd(2, 5, 1, 64'h1122334455667788, 64'h0, 0, 1'b1);
    run_cmd(3, 2, 1, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 1'b0);
    run_cmd(4, 0, 0, 64'h0, 64'h0, 0, 1'b1);
    run_cmd(5, 7, 0, 64'h0, 64'hAAAA55551234FFFF, 5, 1'b0);
    run_cmd(6, 1, 1, 64'h0, 64'h0, 0, 1'b0);
    run_cmd(0, 4, 0, 64'h0, 64'h0, 0, 1'b0);
    run_cmd(5, 0, 1, 64'h0, 64'h0123456789ABCDEF, 0, 1'b1);

    // Abandon a matmul after ten wait cycles; rsp_data still holds the last read.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check("mmr_busy", 64'(busy),    64'h1);
      check("mmr_done", 64'(mm_done), 64'h0);
    end
    #2 rst = 1'b1;
    #1;
    check("arst_ready",  64'(cmd_ready), 64'h0);
    check("arst_busy",   64'(busy),      64'h0);
    check("arst_rspv",   64'(rsp_valid), 64'h0);
    check("arst_rspd",   rsp_data,       64'h0);
    check("arst_mmdone", 64'(mm_done),   64'h0);
    check("arst_err",    64'(err),       64'h0);
    check_idle_bus("arst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_mmdone", 64'(mm_done), 64'h0);
      check("hold_busy",   64'(busy),    64'h0);
    end
    rst = 1'b0;
    #1;
    check("rel2_ready", 64'(cmd_ready), 64'h1);
    run_cmd(4, 0, 0, 64'h0, 64'h0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
